// File: rtl/button_scan_ctrl_pkg.sv
// button_scan_ctrl_pkg: shared scan states, event layout and parameter checks for the button scanner
`ifndef BUTTON_SCAN_CTRL_PKG_SV
`define BUTTON_SCAN_CTRL_PKG_SV
`define BSC_CHECK(c, m) if (!(c)) $error(m);
package button_scan_ctrl_pkg;
  typedef enum logic {IDLE, SCAN} scan_state_e;
  localparam int EVT_PRESS_BIT = 0;
  localparam int EVT_ID_LSB = 1;
  function automatic int evt_idw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int evt_w(input int n);
    return evt_idw(n) + 1;
  endfunction
endpackage
`endif

// File: rtl/button_evt_fifo.sv
// button_evt_fifo: synchronous event queue with push/pop, full/empty and async active-low reset
module button_evt_fifo #(
  parameter int W = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp == AW'(DEPTH-1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == AW'(DEPTH-1) ? '0 : rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/button_scan_ctrl.sv
// button_scan_ctrl: round-robin shared debounce of N buttons feeding a press/release event queue
module button_scan_ctrl import button_scan_ctrl_pkg::*; #(
  parameter int N_BUTTONS = 4,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 8,
  parameter int CNT_W = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW = evt_idw(N_BUTTONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [IDW-1:0]       evt_id,
  output logic                 evt_press,
  output logic                 overflow,
  input  logic                 clr_overflow
);
  localparam int EVT_W = evt_w(N_BUTTONS);
  localparam int PW = $clog2(TICK_DIV);
  `BSC_CHECK(N_BUTTONS >= 1, "N_BUTTONS must be >= 1")
  `BSC_CHECK(TICK_DIV >= N_BUTTONS + 2, "TICK_DIV must be >= N_BUTTONS+2")
  `BSC_CHECK(STABLE_TICKS >= 1, "STABLE_TICKS must be >= 1")
  `BSC_CHECK(STABLE_TICKS - 1 < (1 << CNT_W), "CNT_W too narrow for STABLE_TICKS-1")
  `BSC_CHECK(FIFO_DEPTH >= 1 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0, "FIFO_DEPTH must be a power of 2")
  logic [N_BUTTONS-1:0] s1, s2;
  logic [PW-1:0] pre;
  logic [CNT_W-1:0] cnt [N_BUTTONS];
  scan_state_e state, nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic tick, last, hit, acc, drop, pop, full, empty;
  logic [EVT_W-1:0] dout;
  assign tick = pre == PW'(TICK_DIV-1);
  assign last = ptr == IDW'(N_BUTTONS-1);
  assign pop = evt_valid && evt_ready;
  assign drop = acc && full && !pop;
  always_comb begin
    hit = state == SCAN && s2[ptr] != btn_state[ptr];
    acc = hit && cnt[ptr] == CNT_W'(STABLE_TICKS-1);
    nxt = state == IDLE ? (tick ? SCAN : IDLE) : (last ? IDLE : SCAN);
    ptr_nxt = state == IDLE ? '0 : ptr + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
    end else begin
      state <= nxt;
      ptr <= ptr_nxt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      pre <= '0;
      cnt <= '{default: '0};
      btn_state <= '0;
      overflow <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      pre <= tick ? '0 : pre + 1'b1;
      if (state == SCAN) cnt[ptr] <= hit && !acc ? cnt[ptr] + 1'b1 : '0;
      if (acc) btn_state[ptr] <= ~btn_state[ptr];
      overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
    end
  button_evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(acc),
    .din({ptr, ~btn_state[ptr]}),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  assign evt_valid = !empty;
  assign evt_id = dout[EVT_W-1:EVT_ID_LSB];
  assign evt_press = dout[EVT_PRESS_BIT];
endmodule

// File: tb/tb_button_scan_ctrl.sv
// tb_button_scan_ctrl: vector table, corner sequences and randomized run against a sample-level reference model
module tb_button_scan_ctrl;
  localparam int N = 4;
  localparam int TD = 8;
  localparam int ST = 3;
  localparam int FD = 4;
  logic clk = 0;
  logic rst_n = 1;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_state;
  logic evt_valid, evt_press, overflow;
  logic evt_ready = 0;
  logic clr_overflow = 0;
  logic [1:0] evt_id;
  int tests = 0;
  int fails = 0;
  bit saw_valid;
  int m_e;
  logic [3:0] m_s1, m_s2, m_st;
  int m_n [N];
  logic [2:0] m_q [$];
  logic m_ov;
  typedef struct {
    logic [3:0] raw;
    int n;
    logic [3:0] st;
    logic v;
    logic [1:0] id;
    logic p;
  } vec_t;
  vec_t tbl [8];
  button_scan_ctrl #(.N_BUTTONS(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .CNT_W(4), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id(evt_id),
    .evt_press(evt_press),
    .overflow(overflow),
    .clr_overflow(clr_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_e);
    end
  endtask
  task automatic model_reset;
    m_e = 0;
    m_s1 = '0;
    m_s2 = '0;
    m_st = '0;
    foreach (m_n[i]) m_n[i] = 0;
    m_q.delete();
    m_ov = 0;
  endtask
  task automatic model_edge(input logic [3:0] raw, input logic rdy, input logic clr);
    logic [3:0] smp;
    logic [2:0] ev;
    bit acc, pop, full;
    smp = m_s2;
    acc = 0;
    ev = '0;
    m_e++;
    pop = rdy && m_q.size() > 0;
    full = m_q.size() == FD;
    if (m_e > TD && (m_e - 1) % TD < N) begin
      int i;
      i = (m_e - 1) % TD;
      if (smp[i] == m_st[i]) m_n[i] = 0;
      else begin
        m_n[i]++;
        if (m_n[i] == ST) begin
          m_n[i] = 0;
          m_st[i] = ~m_st[i];
          acc = 1;
          ev = {2'(i), m_st[i]};
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (acc && (!full || pop)) m_q.push_back(ev);
    if (acc && full && !pop) m_ov = 1;
    else if (clr) m_ov = 0;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask
  task automatic cyc(input logic [3:0] raw, input logic rdy, input logic clr);
    btn_raw = raw;
    evt_ready = rdy;
    clr_overflow = clr;
    @(posedge clk);
    model_edge(raw, rdy, clr);
    #1;
    if (evt_valid) saw_valid = 1;
    chk("model_state", 8'(btn_state), 8'(m_st));
    chk("model_valid", 8'(evt_valid), 8'(m_q.size() > 0));
    chk("model_overflow", 8'(overflow), 8'(m_ov));
    if (m_q.size() > 0) chk("model_head", 8'({evt_id, evt_press}), 8'(m_q[0]));
  endtask
  task automatic run_to(input logic [3:0] raw, input logic rdy, input int e);
    while (m_e < e) cyc(raw, rdy, 0);
  endtask
  task automatic do_reset;
    #2 rst_n = 0;
    #1;
    chk("rst_state", 8'(btn_state), 8'h0);
    chk("rst_valid", 8'(evt_valid), 8'h0);
    chk("rst_id", 8'(evt_id), 8'h0);
    chk("rst_press", 8'(evt_press), 8'h0);
    chk("rst_overflow", 8'(overflow), 8'h0);
    model_reset();
    evt_ready = 0;
    clr_overflow = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic expect_head(input string name, input logic [1:0] id, input logic p);
    chk({name, "_valid"}, 8'(evt_valid), 8'h1);
    chk({name, "_id"}, 8'(evt_id), 8'(id));
    chk({name, "_press"}, 8'(evt_press), 8'(p));
  endtask
  initial begin
    logic [3:0] r;
    logic rdy;
    tbl = '{
      '{4'b0100, 26, 4'b0000, 1'b0, 2'd0, 1'b0},
      '{4'b0100,  1, 4'b0100, 1'b1, 2'd2, 1'b1},
      '{4'b0100,  1, 4'b0100, 1'b0, 2'd0, 1'b0},
      '{4'b1101, 20, 4'b0100, 1'b0, 2'd0, 1'b0},
      '{4'b1101,  1, 4'b0101, 1'b1, 2'd0, 1'b1},
      '{4'b1101,  1, 4'b0101, 1'b0, 2'd0, 1'b0},
      '{4'b1101,  2, 4'b1101, 1'b1, 2'd3, 1'b1},
      '{4'b1101,  1, 4'b1101, 1'b0, 2'd0, 1'b0}
    };
    do_reset();
    for (int k = 0; k < 8; k++) begin
      repeat (tbl[k].n) cyc(tbl[k].raw, 1, 0);
      chk($sformatf("tbl%0d_state", k), 8'(btn_state), 8'(tbl[k].st));
      chk($sformatf("tbl%0d_valid", k), 8'(evt_valid), 8'(tbl[k].v));
      if (tbl[k].v) chk($sformatf("tbl%0d_head", k), 8'({evt_id, evt_press}), 8'({tbl[k].id, tbl[k].p}));
    end
    do_reset();
    saw_valid = 0;
    for (int t = 0; t < 20; t++) repeat (TD) cyc(t % 2 == 0 ? 4'b0010 : 4'b0000, 1, 0);
    chk("bounce_no_event", 8'(saw_valid), 8'h0);
    chk("bounce_state", 8'(btn_state), 8'h0);
    do_reset();
    run_to(4'b1111, 0, 28);
    run_to(4'b1110, 0, 48);
    cyc(4'b1110, 0, 1);
    chk("ovf_drop_beats_clear", 8'(overflow), 8'h1);
    chk("ovf_state", 8'(btn_state), 8'b1110);
    for (int k = 0; k < 4; k++) begin
      expect_head($sformatf("ovf_drain%0d", k), 2'(k), 1'b1);
      cyc(4'b1110, 1, 0);
    end
    chk("ovf_empty", 8'(evt_valid), 8'h0);
    chk("ovf_sticky", 8'(overflow), 8'h1);
    cyc(4'b1110, 1, 1);
    chk("ovf_cleared", 8'(overflow), 8'h0);
    do_reset();
    run_to(4'b1111, 0, 28);
    run_to(4'b1110, 0, 48);
    cyc(4'b1110, 1, 0);
    chk("fullpop_no_ovf", 8'(overflow), 8'h0);
    expect_head("fullpop_d0", 2'd1, 1'b1);
    cyc(4'b1110, 1, 0);
    expect_head("fullpop_d1", 2'd2, 1'b1);
    cyc(4'b1110, 1, 0);
    expect_head("fullpop_d2", 2'd3, 1'b1);
    cyc(4'b1110, 1, 0);
    expect_head("fullpop_d3", 2'd0, 1'b0);
    cyc(4'b1110, 1, 0);
    chk("fullpop_empty", 8'(evt_valid), 8'h0);
    do_reset();
    run_to(4'b0011, 0, 33);
    expect_head("midrst_pre", 2'd0, 1'b1);
    do_reset();
    run_to(4'b0011, 1, 24);
    chk("midrst_quiet", 8'(evt_valid), 8'h0);
    cyc(4'b0011, 1, 0);
    expect_head("midrst_restart", 2'd0, 1'b1);
    do_reset();
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(29) == 0) r[b] = ~r[b];
      rdy = (i / 200) % 3 == 0 ? 1'b0 : 1'($urandom_range(3) != 0);
      cyc(r, rdy, 1'($urandom_range(49) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
